// File: rtl/axis_latency_pipe_if.sv
// AXI-Stream bundle with a 128-bit tuser side channel.
interface axis_latency_pipe_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] tdata;
  logic             tlast;
  logic             tvalid;
  logic             tready;
  logic [127:0]     tuser;

  modport master (output tdata, tlast, tvalid, tuser, input tready);
  modport slave  (input tdata, tlast, tvalid, tuser, output tready);
endinterface

// File: rtl/axis_latency_pipe.sv
// Configurable-depth AXI-Stream delay line: beats are timestamped on entry,
// latency is reported in tuser on exit and folded into per-packet statistics.
module axis_latency_pipe #(
  parameter int WIDTH     = 32,
  parameter int MAX_DEPTH = 16,
  parameter int DW        = 5,
  parameter int TS_W      = 48
) (
  input  logic                ce_clk,
  input  logic                reset,
  input  logic [DW-1:0]       cfg_depth,
  input  logic                stats_clr,
  input  logic [63:0]         timer,
  input  logic [63:0]         header,
  axis_latency_pipe_if.slave  s,
  axis_latency_pipe_if.master m,
  output logic [TS_W-1:0]     lat_last,
  output logic [TS_W-1:0]     lat_min,
  output logic [TS_W-1:0]     lat_max,
  output logic [31:0]         pkt_cnt,
  output logic                busy
);
  localparam logic [DW-1:0] MAXD = DW'(MAX_DEPTH);

  logic [1:0]                     r_rst_sync;
  logic                           w_rst_n;
  logic [DW-1:0]                  r_depth;
  logic [DW-1:0]                  w_clamp;
  logic [MAX_DEPTH:1]             r_vld, r_last, r_eob, w_act;
  logic [MAX_DEPTH:1][WIDTH-1:0]  r_data;
  logic [MAX_DEPTH:1][TS_W-1:0]   r_stamp;
  logic                           w_adv, w_hs, r_sof;
  logic [TS_W-1:0]                w_lat;
  logic                           w_unused;

  assign w_unused = &{1'b0, s.tuser[127:126], s.tuser[124:0], timer[63:TS_W]};

  // Assert immediately, release two edges later so nothing is accepted near the release edge.
  always_ff @(posedge ce_clk or negedge reset)
    if (!reset) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  assign w_rst_n = r_rst_sync[1];

  always_comb begin
    w_clamp = cfg_depth;
    if (cfg_depth == '0)        w_clamp = DW'(1);
    else if (cfg_depth > MAXD)  w_clamp = MAXD;
  end

  always_comb begin
    w_act = '0;
    for (int k = 1; k <= MAX_DEPTH; k++) w_act[k] = (DW'(k) <= r_depth);
  end

  assign busy     = |(r_vld & w_act);
  assign w_adv    = (m.tready | ~m.tvalid) & w_rst_n;
  assign s.tready = w_adv;

  assign m.tvalid = r_vld[r_depth];
  assign m.tlast  = r_last[r_depth];
  assign m.tdata  = r_data[r_depth];
  assign w_lat    = timer[TS_W-1:0] - r_stamp[r_depth];
  assign m.tuser  = {header, r_eob[r_depth], 15'h0, 48'(w_lat)};
  assign w_hs     = m.tvalid & m.tready;

  // Depth only moves while the active stages are empty, so no beat changes latency in flight.
  always_ff @(posedge ce_clk or negedge w_rst_n)
    if (!w_rst_n)   r_depth <= DW'(1);
    else if (!busy) r_depth <= w_clamp;

  always_ff @(posedge ce_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_vld   <= '0;
      r_last  <= '0;
      r_eob   <= '0;
      r_data  <= '0;
      r_stamp <= '0;
    end else begin
      if (w_adv) begin
        r_vld[1]   <= s.tvalid;
        r_last[1]  <= s.tlast;
        r_eob[1]   <= s.tuser[125];
        r_data[1]  <= s.tdata;
        r_stamp[1] <= timer[TS_W-1:0];
        for (int k = 2; k <= MAX_DEPTH; k++) begin
          r_vld[k]   <= r_vld[k-1];
          r_last[k]  <= r_last[k-1];
          r_eob[k]   <= r_eob[k-1];
          r_data[k]  <= r_data[k-1];
          r_stamp[k] <= r_stamp[k-1];
        end
      end
      for (int k = 1; k <= MAX_DEPTH; k++)
        if (!w_act[k]) r_vld[k] <= 1'b0;
    end

  always_ff @(posedge ce_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_sof    <= 1'b1;
      lat_last <= '0;
      lat_min  <= '1;
      lat_max  <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (w_hs) r_sof <= m.tlast;
      if (stats_clr) begin
        lat_last <= '0;
        lat_min  <= '1;
        lat_max  <= '0;
        pkt_cnt  <= '0;
      end else if (w_hs && r_sof) begin
        lat_last <= w_lat;
        pkt_cnt  <= pkt_cnt + 32'd1;
        if (w_lat < lat_min) lat_min <= w_lat;
        if (w_lat > lat_max) lat_max <= w_lat;
      end
    end
endmodule
